// File: rtl/abcd_pkg.sv
// abcd_pkg: shared types and constants for the A/B/C/D stimulus stage.
//   vec4_t     - 4-bit stimulus vector, bit 3 = A ... bit 0 = D
//   src_mode_t - source select (switches or automatic sweep)
//   VEC_MAX    - last sweep value before wrapping to zero
package abcd_pkg;

    typedef logic [3:0] vec4_t;

    typedef enum logic {
        MODE_SWITCH = 1'b0,
        MODE_SWEEP  = 1'b1
    } src_mode_t;

    localparam vec4_t VEC_MAX  = 4'd15;
    localparam vec4_t VEC_ZERO = 4'd0;

    // Next sweep value, modulo 16.
    function automatic vec4_t vec_next(input vec4_t v);
        return vec4_t'(v + 4'd1);
    endfunction

    // True when stepping v wraps the sweep back to zero.
    function automatic logic vec_wraps(input vec4_t v);
        return (v == VEC_MAX);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: single-bit debouncer for an already-synchronised input.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   din  - synchronised raw level
//   dout - debounced level; follows din only after din has differed from
//          it for DEBOUNCE_CYCLES consecutive cycles
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter would reach DEBOUNCE_CYCLES on this edge; accept then.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          stable_r;

    // Count consecutive disagreeing cycles, accept the new level at terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else if (din == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= din;
            cnt_r    <= '0;
        end else begin
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    assign dout = stable_r;

endmodule

// File: rtl/abcd_source.sv
// abcd_source: drives the A/B/C/D inputs of the downstream logic block.
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   sw[3:0]    - raw asynchronous switches, sw[3] -> A ... sw[0] -> D
//   mode       - 0 = debounced switches, 1 = automatic 0..15 sweep
//   A,B,C,D    - registered stimulus vector
//   upd        - one-cycle pulse in the cycle A..D take a new value
//   sweep_done - one-cycle pulse when the sweep wraps 15 -> 0
module abcd_source
    import abcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SWEEP_DIV       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       mode,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       upd,
    output logic       sweep_done
);

    localparam int DW = $clog2(SWEEP_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SWEEP_DIV - 1);

    vec4_t         sync1_r;
    vec4_t         sync2_r;
    vec4_t         stable_s;
    src_mode_t     mode_s;
    src_mode_t     mode_q_r;
    vec4_t         vec_r;
    logic [DW-1:0] div_r;
    vec4_t         out_r;
    logic          upd_r;
    logic          done_r;

    vec4_t         vec_nxt_s;
    logic [DW-1:0] div_nxt_s;
    vec4_t         out_nxt_s;
    logic          wrap_s;

    assign mode_s = src_mode_t'(mode);

    // One debouncer per switch bit; they keep running during sweep mode.
    for (genvar i = 0; i < 4; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (sync2_r[i]),
            .dout (stable_s[i])
        );
    end

    // Next sweep state and output selection.
    always_comb begin
        vec_nxt_s = VEC_ZERO;
        div_nxt_s = '0;
        out_nxt_s = VEC_ZERO;
        wrap_s    = 1'b0;
        case (mode_s)
            MODE_SWEEP: begin
                if (mode_q_r == MODE_SWITCH) begin
                    // Entering sweep: restart from zero with a full step ahead.
                    vec_nxt_s = VEC_ZERO;
                    div_nxt_s = '0;
                end else if (div_r == DIV_LAST) begin
                    vec_nxt_s = vec_next(vec_r);
                    div_nxt_s = '0;
                    wrap_s    = vec_wraps(vec_r);
                end else begin
                    vec_nxt_s = vec_r;
                    div_nxt_s = div_r + DW'(1);
                end
                out_nxt_s = vec_nxt_s;
            end
            MODE_SWITCH: begin
                // Any pending sweep step is dropped; switch data wins.
                out_nxt_s = stable_s;
            end
            default: begin
                out_nxt_s = stable_s;
            end
        endcase
    end

    // Synchroniser, sweep state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= VEC_ZERO;
            sync2_r  <= VEC_ZERO;
            mode_q_r <= MODE_SWITCH;
            vec_r    <= VEC_ZERO;
            div_r    <= '0;
            out_r    <= VEC_ZERO;
            upd_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            sync1_r  <= sw;
            sync2_r  <= sync1_r;
            mode_q_r <= mode_s;
            vec_r    <= vec_nxt_s;
            div_r    <= div_nxt_s;
            out_r    <= out_nxt_s;
            upd_r    <= (out_nxt_s != out_r);
            done_r   <= wrap_s;
        end
    end

    assign A          = out_r[3];
    assign B          = out_r[2];
    assign C          = out_r[1];
    assign D          = out_r[0];
    assign upd        = upd_r;
    assign sweep_done = done_r;

endmodule

// File: tb/tb_abcd_source.sv
// tb_abcd_source: self-checking bench for abcd_source. A directed table,
// hand-written corner sequences and a random run are all checked against a
// behavioural model built from windowed switch history and elapsed sweep time.
module tb_abcd_source;

    localparam int DB  = 4;
    localparam int DIV = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] sw   = 4'h0;
    logic       A, B, C, D, upd, sweep_done;

    int vectors     = 0;
    int miscompares = 0;

    abcd_source #(
        .DEBOUNCE_CYCLES(DB),
        .SWEEP_DIV      (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .mode       (mode),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .upd        (upd),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [3:0] m_s1 = 4'h0;
    logic [3:0] m_s2 = 4'h0;
    logic [3:0] m_win[$];
    logic [3:0] m_stable = 4'h0;
    logic [3:0] m_out = 4'h0;
    logic       m_upd = 1'b0;
    logic       m_done = 1'b0;
    logic       m_prev_mode = 1'b0;
    int         m_pos = 0;

    // A bit is accepted once its last DB synchronised samples all disagree
    // with the accepted level; the sweep value is elapsed time / DIV mod 16.
    task automatic model_edge();
        logic [3:0] new_out;
        logic [3:0] pre_stable;
        bit         flip;
        if (rst) begin
            m_s1 = 4'h0; m_s2 = 4'h0; m_win.delete();
            m_stable = 4'h0; m_out = 4'h0; m_upd = 1'b0; m_done = 1'b0;
            m_prev_mode = 1'b0; m_pos = 0;
        end else begin
            pre_stable = m_stable;
            m_win.push_back(m_s2);
            if (m_win.size() > DB) void'(m_win.pop_front());
            for (int b = 0; b < 4; b++) begin
                if (m_win.size() == DB) begin
                    flip = 1'b1;
                    foreach (m_win[k]) if (m_win[k][b] == pre_stable[b]) flip = 1'b0;
                    if (flip) m_stable[b] = ~m_stable[b];
                end
            end
            m_s2 = m_s1;
            m_s1 = sw;
            m_done = 1'b0;
            if (mode) begin
                if (!m_prev_mode) m_pos = 0;
                else m_pos++;
                new_out = 4'((m_pos / DIV) % 16);
                m_done  = m_prev_mode && ((m_pos % (16 * DIV)) == 0);
            end else begin
                new_out = pre_stable;
            end
            m_prev_mode = mode;
            m_upd = (new_out != m_out);
            m_out = new_out;
        end
    endtask

    // One clock edge, advance the model, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
        if ({A, B, C, D} !== m_out || upd !== m_upd || sweep_done !== m_done) begin
            miscompares++;
            $display("FAIL model t=%0t: got abcd=%b upd=%b done=%b, want abcd=%b upd=%b done=%b",
                     $time, {A, B, C, D}, upd, sweep_done, m_out, m_upd, m_done);
        end
    endtask

    task automatic expect_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic       mode;
        logic [3:0] abcd;
        logic       upd;
        logic       done;
    } row_t;

    row_t tbl[$];

    task automatic add_row(input logic r, input logic [3:0] s, input logic m,
                           input logic [3:0] a, input logic u, input logic d);
        row_t v;
        v.rst = r; v.sw = s; v.mode = m; v.abcd = a; v.upd = u; v.done = d;
        tbl.push_back(v);
    endtask

    int upd_cnt;
    int done_cnt;
    int b_seen;

    initial begin
        // Reset held 3 cycles with switches high, then 2+DB edge latency.
        for (int i = 0; i < 3; i++) add_row(1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add_row(1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add_row(1'b0, 4'hF, 1'b0, 4'hF, 1'b1, 1'b0);
        add_row(1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0);
        // Clean 0000 -> 1010 step.
        add_row(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add_row(1'b0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0);
        add_row(1'b0, 4'hA, 1'b0, 4'hA, 1'b1, 1'b0);
        add_row(1'b0, 4'hA, 1'b0, 4'hA, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; sw = tbl[i].sw; mode = tbl[i].mode;
            step();
            vectors++;
            if ({A, B, C, D} !== tbl[i].abcd || upd !== tbl[i].upd || sweep_done !== tbl[i].done) begin
                miscompares++;
                $display("FAIL table[%0d]: got abcd=%b upd=%b done=%b, want abcd=%b upd=%b done=%b",
                         i, {A, B, C, D}, upd, sweep_done, tbl[i].abcd, tbl[i].upd, tbl[i].done);
            end
        end

        // Glitch rejection: 3-cycle pulse on sw[2] must vanish.
        rst = 1'b1; sw = 4'h0; mode = 1'b0; step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        upd_cnt = 0;
        sw = 4'h4;
        for (int i = 0; i < 3; i++) begin step(); upd_cnt += int'(upd); end
        sw = 4'h0;
        for (int i = 0; i < 10; i++) begin step(); upd_cnt += int'(upd); end
        expect_int("glitch3_upd", upd_cnt, 0);
        expect_int("glitch3_abcd", int'({A, B, C, D}), 0);

        // 4-cycle pulse is accepted: B rises, then falls again.
        upd_cnt = 0; b_seen = 0;
        sw = 4'h4;
        for (int i = 0; i < 4; i++) begin step(); upd_cnt += int'(upd); b_seen |= int'(B); end
        sw = 4'h0;
        for (int i = 0; i < 10; i++) begin step(); upd_cnt += int'(upd); b_seen |= int'(B); end
        expect_int("pulse4_upd", upd_cnt, 2);
        expect_int("pulse4_b_seen", b_seen, 1);
        expect_int("pulse4_abcd", int'({A, B, C, D}), 0);

        // Full sweep from reset release.
        rst = 1'b1; mode = 1'b1; step();
        rst = 1'b0; step();
        upd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 16 * DIV; i++) begin
            step();
            upd_cnt += int'(upd); done_cnt += int'(sweep_done);
        end
        expect_int("sweep_upd", upd_cnt, 16);
        expect_int("sweep_done", done_cnt, 1);
        expect_int("sweep_wrap_abcd", int'({A, B, C, D}), 0);
        expect_int("sweep_wrap_pulse", int'(sweep_done), 1);

        // Mode change mid-sweep.
        rst = 1'b1; sw = 4'h3; mode = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 7 * DIV + 5; i++) step();
        expect_int("mid_sweep_vec7", int'({A, B, C, D}), 7);
        mode = 1'b0; step();
        expect_int("to_switch_abcd", int'({A, B, C, D}), 3);
        expect_int("to_switch_upd", int'(upd), 1);
        mode = 1'b1; step();
        expect_int("to_sweep_abcd", int'({A, B, C, D}), 0);
        expect_int("to_sweep_upd", int'(upd), 1);

        // Reset during sweep at 12 with a debounce count in flight.
        rst = 1'b1; sw = 4'h0; mode = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 12 * DIV + 1; i++) step();
        expect_int("pre_reset_vec12", int'({A, B, C, D}), 12);
        sw = 4'hF;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; step();
        expect_int("mid_reset_abcd", int'({A, B, C, D}), 0);
        expect_int("mid_reset_flags", int'({upd, sweep_done}), 0);
        rst = 1'b0;
        for (int i = 0; i < DIV; i++) step();
        expect_int("restart_hold0", int'({A, B, C, D}), 0);
        step();
        expect_int("restart_first_step", int'({A, B, C, D}), 1);
        expect_int("restart_first_upd", int'(upd), 1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) sw = 4'($urandom);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/abcd_source.md
Name: abcd_source

Overview:
- Stimulus stage that drives the four inputs A, B, C, D of the downstream 4-input logic-function block. That block's Y output goes to an LED.
- Two sources for the 4-bit vector:
  - switch mode: four board switches, synchronised and debounced;
  - sweep mode: an automatic 0..15 counter, so the whole truth table can be walked on hardware.
- All outputs are registered, so the downstream combinational function sees glitch-free inputs.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive synchronised cycles a switch must hold a new level before it is accepted. Legal range is 1 or more; the board build uses 1_000_000.
- SWEEP_DIV, default 8: clock cycles per sweep step. Legal range is 2 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  4  raw switch levels, asynchronous to clk; sw[3] maps to A, sw[0] to D.
- mode  input  1  0 = switch mode, 1 = sweep mode; synchronous to clk.
- A  output  1  vector bit 3.
- B  output  1  vector bit 2.
- C  output  1  vector bit 1.
- D  output  1  vector bit 0.
- upd  output  1  one-cycle pulse in the same cycle A..D take a new value.
- sweep_done  output  1  one-cycle pulse when the sweep wraps from 15 to 0.

Behaviour:
- Reset (rst high at an edge):
  - A, B, C, D, upd and sweep_done are 0.
  - Sync flops, debounced state, debounce counters, sweep vector and divider are all 0.
  - Reset has priority over every other event, including mid-debounce and mid-sweep.
- Synchroniser: a 2-flop chain per sw bit. Only the second flop (sync2) feeds the debouncers.
- Debouncer, per bit:
  - Holds `stable` and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, `stable` takes sync2 at that edge and the counter clears.
  - Any return to equality before the terminal count clears the counter, so a glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- Switch-mode latency:
  - sw is first sampled at its new level at edge 0; sync2 shows it at edge 1.
  - `stable` updates at edge 1+DEBOUNCE_CYCLES; A..D update at edge 2+DEBOUNCE_CYCLES, with upd high for that cycle.
  - Each bit debounces independently, so bits may change on different cycles. Every change generates upd.
- Sweep mode:
  - The divider counts 0..SWEEP_DIV-1.
  - At terminal count the divider returns to 0 and the vector increments modulo 16.
  - A 15 -> 0 increment asserts sweep_done in the same cycle A..D show 0.
- Mode transitions:
  - The registered copy of mode is mode_q.
  - At an edge where mode is 1 and mode_q is 0: the vector and divider load 0, and A..D show 0000 from that edge. upd pulses only if A..D actually changed. The first increment occurs SWEEP_DIV edges later.
  - At an edge where mode is 0: A..D take the debounced value at that edge. Debouncers keep running during sweep, so there is no re-debounce delay. upd pulses if the value differs.
- upd definition: upd = (next A..D != current A..D), registered with the outputs. It is never asserted while rst is high or in the cycle after reset.
- Simultaneous events: a sweep step coinciding with a mode change to 0 is discarded; switch data wins.

Decomposition:
- Package abcd_pkg:
  - typedef vec4_t (logic [3:0]);
  - enum src_mode_t {MODE_SWITCH = 1'b0, MODE_SWEEP = 1'b1};
  - localparam VEC_MAX = 4'd15.
- Sub-module debounce_bit: parameter DEBOUNCE_CYCLES; ports clk, rst, din (sync2), dout (stable). Instantiated 4 times via generate.
- The synchroniser, sweep counter and output mux stay in abcd_source.

Test Plan:
- Reset: hold rst for 3 cycles with sw = 4'b1111 and mode = 0 -> A..D = 0, upd = 0, sweep_done = 0 throughout. After release, A..D = 1111 exactly 2+4 edges later, with a single upd pulse.
- Switch step: with DEBOUNCE_CYCLES = 4, sw goes 0000 -> 1010 at edge 0 -> {A,B,C,D} = 1010 at edge 6, upd high only in that cycle.
- Glitch rejection: sw[2] pulses high for 3 cycles, then returns -> A..D unchanged, upd never asserted. A 4-cycle pulse with 2 cycles of slack -> B rises, then falls again.
- Full sweep: mode = 1 from reset release -> vector goes 0, 1, ..., 15, 0 every 8 cycles. sweep_done pulses once at the wrap; upd pulses 16 times per 128 cycles.
- Mode change mid-sweep: at vector 7 with sw = 0011, drop mode to 0 -> A..D = 0011 at the next edge, upd pulses. Raise mode again -> A..D = 0000 at the next edge.
- Reset mid-operation: assert rst while the vector is 12 and a debounce count is at 3 -> everything reads 0 at the next edge. After release in sweep mode, counting restarts from 0.
